uart_rx: RTL and testbench

//   UART receiver; the receive-side counterpart of uart_tx. Samples the serial line and

---
 rtl/uart_rx_if.sv | 18 +
 rtl/uart_rx.sv | 103 ++++++++++
 tb/tb_uart_rx.sv | 136 +++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line, enable and received-byte strobes of the UART receiver
interface uart_rx_if #(parameter int PAYLOAD_BITS = 8);
  logic uart_rxd;
  logic uart_rx_en;
  logic [PAYLOAD_BITS-1:0] uart_rx_data;
  logic uart_rx_valid;
  logic uart_rx_error;
  logic uart_rx_break;
  logic uart_rx_busy;
  modport master (
    output uart_rxd, uart_rx_en,
    input  uart_rx_data, uart_rx_valid, uart_rx_error, uart_rx_break, uart_rx_busy
  );
  modport slave (
    input  uart_rxd, uart_rx_en,
    output uart_rx_data, uart_rx_valid, uart_rx_error, uart_rx_break, uart_rx_busy
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with framing-error and line-break strobes
module uart_rx #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BIT_RATE     = 9600,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1
) (
  input logic clk,
  input logic reset,
  uart_rx_if.slave rx
);
  localparam int CPB = CLK_HZ / BIT_RATE;
  localparam int CW = $clog2(CPB);
  localparam logic [CW-1:0] HALF = CW'(CPB / 2);
  localparam logic [CW-1:0] LAST = CW'(CPB - 1);
  localparam logic [3:0] PB_LAST = 4'(PAYLOAD_BITS - 1);
  localparam logic [3:0] SB_LAST = 4'(STOP_BITS - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, HOLD} state_t;
  state_t state, state_n;
  logic rx_meta, rxs;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0] bits, bits_n;
  logic [PAYLOAD_BITS-1:0] sreg, sreg_n, data_n;
  logic bad, bad_n, valid_n, error_n, brk_n, tick;
  assign tick = cnt == LAST;
  assign rx.uart_rx_busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta          <= 1'b1;
      rxs              <= 1'b1;
      state            <= IDLE;
      cnt              <= '0;
      bits             <= '0;
      sreg             <= '1;
      bad              <= 1'b0;
      rx.uart_rx_data  <= '0;
      rx.uart_rx_valid <= 1'b0;
      rx.uart_rx_error <= 1'b0;
      rx.uart_rx_break <= 1'b0;
    end else begin
      rx_meta          <= rx.uart_rxd;
      rxs              <= rx_meta;
      state            <= state_n;
      cnt              <= cnt_n;
      bits             <= bits_n;
      sreg             <= sreg_n;
      bad              <= bad_n;
      rx.uart_rx_data  <= data_n;
      rx.uart_rx_valid <= valid_n;
      rx.uart_rx_error <= error_n;
      rx.uart_rx_break <= brk_n;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n   = tick ? '0 : cnt + 1'b1;
    bits_n  = bits;
    sreg_n  = sreg;
    bad_n   = bad;
    data_n  = rx.uart_rx_data;
    valid_n = 1'b0;
    error_n = 1'b0;
    brk_n   = 1'b0;
    if (!rx.uart_rx_en) begin
      state_n = IDLE;
      cnt_n   = '0;
      bits_n  = '0;
    end else begin
      case (state)
        IDLE: begin
          cnt_n   = '0;
          bits_n  = '0;
          bad_n   = 1'b0;
          state_n = rxs ? IDLE : START;
        end
        START: if (cnt == HALF) begin
          cnt_n   = '0;
          state_n = rxs ? IDLE : DATA;
        end
        DATA: if (tick) begin
          sreg_n  = (sreg >> 1) | (PAYLOAD_BITS'(rxs) << (PAYLOAD_BITS - 1));
          bits_n  = bits == PB_LAST ? '0 : bits + 1'b1;
          state_n = bits == PB_LAST ? STOP : DATA;
        end
        STOP: if (tick) begin
          bad_n  = bad | ~rxs;
          bits_n = bits + 1'b1;
          if (bits == SB_LAST) begin
            bits_n  = '0;
            valid_n = ~bad_n;
            error_n = bad_n;
            brk_n   = bad_n && sreg == '0;
            data_n  = bad_n ? rx.uart_rx_data : sreg;
            // a low line after a bad stop bit is a break: wait for it to rise before rearming
            state_n = bad_n ? HOLD : IDLE;
          end
        end
        HOLD: state_n = rxs ? IDLE : HOLD;
        default: state_n = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames against uart_rx at 10 clocks per bit
module tb_uart_rx;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0, n_fail = 0;
  int n_valid = 0, n_error = 0, n_break = 0, n_pair = 0;
  logic [7:0] last_data = 8'h00, prev_data = 8'h00;
  uart_rx_if #(.PAYLOAD_BITS(8)) bus();
  uart_rx #(.CLK_HZ(1_000_000), .BIT_RATE(100_000), .PAYLOAD_BITS(8), .STOP_BITS(1)) dut (
    .clk(clk), .reset(reset), .rx(bus.slave)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (bus.uart_rx_valid) begin
      n_valid++;
      prev_data = last_data;
      last_data = bus.uart_rx_data;
    end
    if (bus.uart_rx_error) n_error++;
    if (bus.uart_rx_break) n_break++;
    if (bus.uart_rx_error && bus.uart_rx_break) n_pair++;
  end
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic drive_bit(input logic b);
    bus.uart_rxd = b;
    wait_cyc(10);
  endtask
  task automatic send_frame(input logic [7:0] b, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
    bus.uart_rxd = 1'b1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    int bc;
    logic [7:0] part;
    bus.uart_rxd = 1'b1;
    bus.uart_rx_en = 1'b1;
    wait_cyc(3);
    chk("rst_data", 32'(bus.uart_rx_data), 32'h00);
    chk("rst_valid", 32'(bus.uart_rx_valid), 32'h0);
    chk("rst_error", 32'(bus.uart_rx_error), 32'h0);
    chk("rst_break", 32'(bus.uart_rx_break), 32'h0);
    chk("rst_busy", 32'(bus.uart_rx_busy), 32'h0);
    reset = 1'b0;
    wait_cyc(5);
    send_frame(8'h1E, 1'b1);
    wait_cyc(20);
    chk("t1_nvalid", 32'(n_valid), 32'd1);
    chk("t1_strobe_data", 32'(last_data), 32'h1E);
    chk("t1_data", 32'(bus.uart_rx_data), 32'h1E);
    chk("t1_nerror", 32'(n_error), 32'd0);
    chk("t1_busy", 32'(bus.uart_rx_busy), 32'h0);
    send_frame(8'h55, 1'b1);
    send_frame(8'hA3, 1'b1);
    wait_cyc(20);
    chk("t2_nvalid", 32'(n_valid), 32'd3);
    chk("t2_first", 32'(prev_data), 32'h55);
    chk("t2_second", 32'(last_data), 32'hA3);
    chk("t2_nerror", 32'(n_error), 32'd0);
    bus.uart_rxd = 1'b0;
    wait_cyc(3);
    bus.uart_rxd = 1'b1;
    bc = 0;
    for (int i = 0; i < 14; i++) begin
      wait_cyc(1);
      if (bus.uart_rx_busy) bc++;
    end
    chk("t3_busy_len_ok", 32'(bc >= 1 && bc <= 8), 32'd1);
    chk("t3_nvalid", 32'(n_valid), 32'd3);
    chk("t3_nerror", 32'(n_error), 32'd0);
    chk("t3_busy", 32'(bus.uart_rx_busy), 32'h0);
    send_frame(8'h3C, 1'b0);
    wait_cyc(20);
    chk("t4_nerror", 32'(n_error), 32'd1);
    chk("t4_nbreak", 32'(n_break), 32'd0);
    chk("t4_nvalid", 32'(n_valid), 32'd3);
    chk("t4_data_kept", 32'(bus.uart_rx_data), 32'hA3);
    bus.uart_rxd = 1'b0;
    wait_cyc(300);
    chk("t5_nerror_low", 32'(n_error), 32'd2);
    bus.uart_rxd = 1'b1;
    wait_cyc(20);
    chk("t5_nerror", 32'(n_error), 32'd2);
    chk("t5_nbreak", 32'(n_break), 32'd1);
    chk("t5_pair", 32'(n_pair), 32'd1);
    send_frame(8'h01, 1'b1);
    wait_cyc(20);
    chk("t5_nvalid", 32'(n_valid), 32'd4);
    chk("t5_data", 32'(bus.uart_rx_data), 32'h01);
    part = 8'hC7;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(part[i]);
    bus.uart_rx_en = 1'b0;
    wait_cyc(2);
    chk("t6_en_busy", 32'(bus.uart_rx_busy), 32'h0);
    bus.uart_rxd = 1'b1;
    wait_cyc(150);
    bus.uart_rx_en = 1'b1;
    wait_cyc(5);
    chk("t6_en_nvalid", 32'(n_valid), 32'd4);
    chk("t6_en_nerror", 32'(n_error), 32'd2);
    chk("t6_en_data", 32'(bus.uart_rx_data), 32'h01);
    send_frame(8'hC7, 1'b1);
    wait_cyc(20);
    chk("t6_en_next_nvalid", 32'(n_valid), 32'd5);
    chk("t6_en_next_data", 32'(bus.uart_rx_data), 32'hC7);
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(part[i]);
    reset = 1'b1;
    wait_cyc(2);
    chk("t6_rst_busy", 32'(bus.uart_rx_busy), 32'h0);
    chk("t6_rst_data", 32'(bus.uart_rx_data), 32'h00);
    bus.uart_rxd = 1'b1;
    reset = 1'b0;
    wait_cyc(150);
    chk("t6_rst_nvalid", 32'(n_valid), 32'd5);
    chk("t6_rst_nerror", 32'(n_error), 32'd2);
    send_frame(8'hC7, 1'b1);
    wait_cyc(20);
    chk("t6_rst_next_nvalid", 32'(n_valid), 32'd6);
    chk("t6_rst_next_data", 32'(bus.uart_rx_data), 32'hC7);
    chk("end_busy", 32'(bus.uart_rx_busy), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
